decode_cycle: RTL and testbench

Decode stage of the five-stage RV32I pipeline. It consumes the IF/ID outputs InstrD, PCD and PCPlus4D from the fetch stage and hosts the 32x32 register file, written from write-back. It generates control signals and the sign-extended immediate, then registers everything into the ID/EX pipeline register that feeds execute, where PCSrcE and PCTargetE are produced.

---
 rtl/decode_cycle_if.sv | 44 ++++
 rtl/decode_cycle.sv | 236 +++++++++++++++++++++++
 tb/tb_decode_cycle.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_cycle_if.sv
// Bundles the IF/ID inputs, the write-back port and the ID/EX outputs
// of the RV32I decode stage so the stage connects through one port.
interface decode_cycle_if;
    // Fetch-side inputs
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    // Write-back port into the register file
    logic        RegWriteW;
    logic [4:0]  RDW;
    logic [31:0] ResultW;
    // Hazard control
    logic        FlushE;
    // ID/EX outputs toward execute
    logic        RegWriteE;
    logic        MemWriteE;
    logic        JumpE;
    logic        BranchE;
    logic        ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] ImmExtE;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;
    logic [4:0]  RdE;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;

    // Upstream pipeline / testbench side
    modport master (
        output InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
        input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
               ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, Rs1E, Rs2E
    );

    // Decode stage side
    modport slave (
        input  InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
        output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
               ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, Rs1E, Rs2E
    );
endinterface

// File: rtl/decode_cycle.sv
// RV32I decode stage: register file with write-through bypass, main and
// ALU decoders, immediate extender and the ID/EX pipeline register.
module decode_cycle (
    input  logic          clk,
    input  logic          rst,
    decode_cycle_if.slave bus
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    typedef enum logic [1:0] {
        ALUOP_ADD  = 2'b00,
        ALUOP_SUB  = 2'b01,
        ALUOP_FUNC = 2'b10
    } alu_op_t;

    logic [31:0] r_regs [32];

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;

    logic        w_RegWrite;
    logic        w_MemWrite;
    logic        w_Jump;
    logic        w_Branch;
    logic        w_ALUSrc;
    logic [1:0]  w_ResultSrc;
    imm_src_t    w_ImmSrc;
    alu_op_t     w_ALUOp;
    logic [2:0]  w_ALUControl;
    logic [31:0] w_ImmExt;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;
    logic        w_wbActive;

    logic        r_RegWriteE;
    logic        r_MemWriteE;
    logic        r_JumpE;
    logic        r_BranchE;
    logic        r_ALUSrcE;
    logic [1:0]  r_ResultSrcE;
    logic [2:0]  r_ALUControlE;
    logic [31:0] r_RD1E;
    logic [31:0] r_RD2E;
    logic [31:0] r_ImmExtE;
    logic [31:0] r_PCE;
    logic [31:0] r_PCPlus4E;
    logic [4:0]  r_RdE;
    logic [4:0]  r_Rs1E;
    logic [4:0]  r_Rs2E;

    assign w_opcode   = bus.InstrD[6:0];
    assign w_rd       = bus.InstrD[11:7];
    assign w_funct3   = bus.InstrD[14:12];
    assign w_rs1      = bus.InstrD[19:15];
    assign w_rs2      = bus.InstrD[24:20];
    assign w_wbActive = bus.RegWriteW && (bus.RDW != 5'd0);

    // Main decoder: opcode to control signals; unknown opcodes become bubbles
    always_comb begin
        w_RegWrite  = 1'b0;
        w_MemWrite  = 1'b0;
        w_Jump      = 1'b0;
        w_Branch    = 1'b0;
        w_ALUSrc    = 1'b0;
        w_ResultSrc = 2'b00;
        w_ImmSrc    = IMM_I;
        w_ALUOp     = ALUOP_ADD;
        unique case (w_opcode)
            OP_LW: begin
                w_RegWrite  = 1'b1;
                w_ALUSrc    = 1'b1;
                w_ResultSrc = 2'b01;
            end
            OP_SW: begin
                w_MemWrite = 1'b1;
                w_ImmSrc   = IMM_S;
                w_ALUSrc   = 1'b1;
            end
            OP_R: begin
                w_RegWrite = 1'b1;
                w_ALUOp    = ALUOP_FUNC;
            end
            OP_IALU: begin
                w_RegWrite = 1'b1;
                w_ALUSrc   = 1'b1;
                w_ALUOp    = ALUOP_FUNC;
            end
            OP_BEQ: begin
                w_Branch = 1'b1;
                w_ImmSrc = IMM_B;
                w_ALUOp  = ALUOP_SUB;
            end
            OP_JAL: begin
                w_RegWrite  = 1'b1;
                w_Jump      = 1'b1;
                w_ImmSrc    = IMM_J;
                w_ResultSrc = 2'b10;
            end
            default: ;
        endcase
    end

    // ALU decoder: ALUOp plus funct3/funct7 bit to the ALU operation
    always_comb begin
        w_ALUControl = ALU_ADD;
        unique case (w_ALUOp)
            ALUOP_SUB:  w_ALUControl = ALU_SUB;
            ALUOP_FUNC: begin
                unique case (w_funct3)
                    3'b000:  w_ALUControl = (bus.InstrD[5] && bus.InstrD[30]) ? ALU_SUB : ALU_ADD;
                    3'b010:  w_ALUControl = ALU_SLT;
                    3'b110:  w_ALUControl = ALU_OR;
                    3'b111:  w_ALUControl = ALU_AND;
                    default: w_ALUControl = ALU_ADD;
                endcase
            end
            default: w_ALUControl = ALU_ADD;
        endcase
    end

    // Immediate extender: reassemble and sign-extend the selected format
    always_comb begin
        w_ImmExt = {{20{bus.InstrD[31]}}, bus.InstrD[31:20]};
        unique case (w_ImmSrc)
            IMM_S: w_ImmExt = {{20{bus.InstrD[31]}}, bus.InstrD[31:25], bus.InstrD[11:7]};
            IMM_B: w_ImmExt = {{20{bus.InstrD[31]}}, bus.InstrD[7], bus.InstrD[30:25],
                               bus.InstrD[11:8], 1'b0};
            IMM_J: w_ImmExt = {{12{bus.InstrD[31]}}, bus.InstrD[19:12], bus.InstrD[20],
                               bus.InstrD[30:21], 1'b0};
            default: w_ImmExt = {{20{bus.InstrD[31]}}, bus.InstrD[31:20]};
        endcase
    end

    // Register reads: x0 is hard zero, same-cycle write-back is forwarded
    always_comb begin
        w_rd1 = r_regs[w_rs1];
        w_rd2 = r_regs[w_rs2];
        if (w_rs1 == 5'd0) begin
            w_rd1 = 32'd0;
        end else if (w_wbActive && (bus.RDW == w_rs1)) begin
            w_rd1 = bus.ResultW;
        end
        if (w_rs2 == 5'd0) begin
            w_rd2 = 32'd0;
        end else if (w_wbActive && (bus.RDW == w_rs2)) begin
            w_rd2 = bus.ResultW;
        end
    end

    // Register file write port; reset wipes the whole array
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 32; k++) begin
                r_regs[k] <= 32'd0;
            end
        end else if (w_wbActive) begin
            r_regs[bus.RDW] <= bus.ResultW;
        end
    end

    // ID/EX pipeline register; a flush loads a full bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || bus.FlushE) begin
            r_RegWriteE   <= 1'b0;
            r_MemWriteE   <= 1'b0;
            r_JumpE       <= 1'b0;
            r_BranchE     <= 1'b0;
            r_ALUSrcE     <= 1'b0;
            r_ResultSrcE  <= 2'b00;
            r_ALUControlE <= 3'b000;
            r_RD1E        <= 32'd0;
            r_RD2E        <= 32'd0;
            r_ImmExtE     <= 32'd0;
            r_PCE         <= 32'd0;
            r_PCPlus4E    <= 32'd0;
            r_RdE         <= 5'd0;
            r_Rs1E        <= 5'd0;
            r_Rs2E        <= 5'd0;
        end else begin
            r_RegWriteE   <= w_RegWrite;
            r_MemWriteE   <= w_MemWrite;
            r_JumpE       <= w_Jump;
            r_BranchE     <= w_Branch;
            r_ALUSrcE     <= w_ALUSrc;
            r_ResultSrcE  <= w_ResultSrc;
            r_ALUControlE <= w_ALUControl;
            r_RD1E        <= w_rd1;
            r_RD2E        <= w_rd2;
            r_ImmExtE     <= w_ImmExt;
            r_PCE         <= bus.PCD;
            r_PCPlus4E    <= bus.PCPlus4D;
            r_RdE         <= w_rd;
            r_Rs1E        <= w_rs1;
            r_Rs2E        <= w_rs2;
        end
    end

    assign bus.RegWriteE   = r_RegWriteE;
    assign bus.MemWriteE   = r_MemWriteE;
    assign bus.JumpE       = r_JumpE;
    assign bus.BranchE     = r_BranchE;
    assign bus.ALUSrcE     = r_ALUSrcE;
    assign bus.ResultSrcE  = r_ResultSrcE;
    assign bus.ALUControlE = r_ALUControlE;
    assign bus.RD1E        = r_RD1E;
    assign bus.RD2E        = r_RD2E;
    assign bus.ImmExtE     = r_ImmExtE;
    assign bus.PCE         = r_PCE;
    assign bus.PCPlus4E    = r_PCPlus4E;
    assign bus.RdE         = r_RdE;
    assign bus.Rs1E        = r_Rs1E;
    assign bus.Rs2E        = r_Rs2E;

endmodule

// File: tb/tb_decode_cycle.sv
// Self-checking bench for decode_cycle: directed scenarios followed by
// random instruction streams compared against an architectural model.
module tb_decode_cycle;

    typedef struct packed {
        logic        regWrite;
        logic        memWrite;
        logic        jump;
        logic        branch;
        logic        aluSrc;
        logic [1:0]  resultSrc;
        logic [2:0]  aluCtl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pcp4;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } exp_t;

    logic clk;
    logic rst;
    decode_cycle_if bus ();

    int nCompared;
    int nMismatched;
    logic [31:0] modelRegs [32];

    decode_cycle dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Architectural register read including same-cycle write-back forwarding
    function automatic logic [31:0] readReg(input logic [4:0] a, input logic rw,
                                            input logic [4:0] rdw, input logic [31:0] res);
        if (a == 5'd0) return 32'd0;
        if (rw && rdw == a) return res;
        return modelRegs[a];
    endfunction

    // Immediates as signed integers from their bit-field definitions
    function automatic logic [31:0] immOf(input logic [31:0] ins);
        int v;
        case (ins[6:0])
            7'h23: begin
                v = int'({ins[31:25], ins[11:7]});
                if (ins[31]) v -= 4096;
            end
            7'h63: begin
                v = int'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
                if (ins[31]) v -= 8192;
            end
            7'h6F: begin
                v = int'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
                if (ins[31]) v -= 2097152;
            end
            default: begin
                v = int'(ins[31:20]);
                if (ins[31]) v -= 4096;
            end
        endcase
        return 32'(v);
    endfunction

    // ALU operation for R-type / I-ALU instructions
    function automatic logic [2:0] funcAlu(input logic [31:0] ins);
        case (ins[14:12])
            3'd0:    return (ins[5] && ins[30]) ? 3'd1 : 3'd0;
            3'd2:    return 3'd5;
            3'd6:    return 3'd3;
            3'd7:    return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    // Expected ID/EX contents one edge after the given decode-cycle inputs
    function automatic exp_t predict(input logic [31:0] ins, input logic [31:0] pc,
                                     input logic rw, input logic [4:0] rdw,
                                     input logic [31:0] res, input logic fl);
        exp_t e;
        e = '0;
        if (fl) return e;
        e.rd   = ins[11:7];
        e.rs1  = ins[19:15];
        e.rs2  = ins[24:20];
        e.pc   = pc;
        e.pcp4 = pc + 32'd4;
        e.rd1  = readReg(ins[19:15], rw, rdw, res);
        e.rd2  = readReg(ins[24:20], rw, rdw, res);
        e.imm  = immOf(ins);
        case (ins[6:0])
            7'h03: begin e.regWrite = 1; e.aluSrc = 1; e.resultSrc = 2'd1; end
            7'h23: begin e.memWrite = 1; e.aluSrc = 1; end
            7'h33: begin e.regWrite = 1; e.aluCtl = funcAlu(ins); end
            7'h13: begin e.regWrite = 1; e.aluSrc = 1; e.aluCtl = funcAlu(ins); end
            7'h63: begin e.branch = 1; e.aluCtl = 3'd1; end
            7'h6F: begin e.regWrite = 1; e.jump = 1; e.resultSrc = 2'd2; end
            default: ;
        endcase
        return e;
    endfunction

    // Compare every ID/EX output with an expected record
    task automatic checkAll(input string tag, input exp_t e);
        checkOutput({tag, " RegWriteE"},   32'(bus.RegWriteE),   32'(e.regWrite));
        checkOutput({tag, " MemWriteE"},   32'(bus.MemWriteE),   32'(e.memWrite));
        checkOutput({tag, " JumpE"},       32'(bus.JumpE),       32'(e.jump));
        checkOutput({tag, " BranchE"},     32'(bus.BranchE),     32'(e.branch));
        checkOutput({tag, " ALUSrcE"},     32'(bus.ALUSrcE),     32'(e.aluSrc));
        checkOutput({tag, " ResultSrcE"},  32'(bus.ResultSrcE),  32'(e.resultSrc));
        checkOutput({tag, " ALUControlE"}, 32'(bus.ALUControlE), 32'(e.aluCtl));
        checkOutput({tag, " RD1E"},        bus.RD1E,             e.rd1);
        checkOutput({tag, " RD2E"},        bus.RD2E,             e.rd2);
        checkOutput({tag, " ImmExtE"},     bus.ImmExtE,          e.imm);
        checkOutput({tag, " PCE"},         bus.PCE,              e.pc);
        checkOutput({tag, " PCPlus4E"},    bus.PCPlus4E,         e.pcp4);
        checkOutput({tag, " RdE"},         32'(bus.RdE),         32'(e.rd));
        checkOutput({tag, " Rs1E"},        32'(bus.Rs1E),        32'(e.rs1));
        checkOutput({tag, " Rs2E"},        32'(bus.Rs2E),        32'(e.rs2));
    endtask

    // Drive one decode cycle, clock it, check ID/EX, then commit the model write
    task automatic applyStimulus(input string tag, input logic [31:0] ins,
                                 input logic [31:0] pc, input logic rw,
                                 input logic [4:0] rdw, input logic [31:0] res,
                                 input logic fl);
        exp_t e;
        bus.InstrD    = ins;
        bus.PCD       = pc;
        bus.PCPlus4D  = pc + 32'd4;
        bus.RegWriteW = rw;
        bus.RDW       = rdw;
        bus.ResultW   = res;
        bus.FlushE    = fl;
        e = predict(ins, pc, rw, rdw, res, fl);
        @(posedge clk);
        #1;
        if (rw && rdw != 5'd0) modelRegs[rdw] = res;
        checkAll(tag, e);
    endtask

    task automatic clearModel();
        for (int k = 0; k < 32; k++) modelRegs[k] = 32'd0;
    endtask

    initial begin
        logic [6:0]  opTable [7];
        logic [31:0] rnd;
        logic [31:0] ins;
        nCompared   = 0;
        nMismatched = 0;
        opTable = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h00};
        clearModel();

        rst           = 1'b0;
        bus.InstrD    = 32'd0;
        bus.PCD       = 32'd0;
        bus.PCPlus4D  = 32'd0;
        bus.RegWriteW = 1'b0;
        bus.RDW       = 5'd0;
        bus.ResultW   = 32'd0;
        bus.FlushE    = 1'b0;

        // Reset held across clock edges, then released between edges
        bus.InstrD = 32'h00A282B3;
        bus.PCD    = 32'h0000_0040;
        repeat (3) @(posedge clk);
        #1;
        checkAll("reset-held", '0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkAll("reset-released", '0);

        // Every register reads zero after reset
        for (int i = 1; i < 32; i++) begin
            ins = (32'(i) << 20) | (32'(i) << 15) | (32'd1 << 7) | 32'h33;
            applyStimulus("rf-zero", ins, 32'h200, 1'b0, 5'd0, 32'd0, 1'b0);
        end

        // Write x5, then add x6,x5,x0 reads it from the array
        applyStimulus("wr-x5", 32'h0000_0000, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        applyStimulus("add", 32'h00028333, 32'h4, 1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("add RD1E const", bus.RD1E, 32'hDEADBEEF);
        checkOutput("add RdE const", 32'(bus.RdE), 32'd6);
        checkOutput("add Rs1E const", 32'(bus.Rs1E), 32'd5);

        // x0 ignores writes; a same-cycle write is bypassed
        applyStimulus("wr-x0", 32'h0000_0000, 32'h8, 1'b1, 5'd0, 32'h1234, 1'b0);
        applyStimulus("rd-x0", 32'h00000433, 32'hC, 1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("x0 RD1E const", bus.RD1E, 32'd0);
        applyStimulus("bypass", 32'h00038433, 32'h10, 1'b1, 5'd7, 32'h55, 1'b0);
        checkOutput("bypass RD1E const", bus.RD1E, 32'h55);

        // Immediates of lw and beq
        applyStimulus("lw", 32'hFFC12083, 32'h14, 1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("lw ImmExtE const", bus.ImmExtE, 32'hFFFFFFFC);
        checkOutput("lw ResultSrcE const", 32'(bus.ResultSrcE), 32'd1);
        applyStimulus("beq", 32'hFE000CE3, 32'h18, 1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("beq ImmExtE const", bus.ImmExtE, 32'hFFFFFFF8);
        checkOutput("beq ALUControlE const", 32'(bus.ALUControlE), 32'd1);

        // jal x1,+8 with PC forwarding
        applyStimulus("jal", 32'h008000EF, 32'h100, 1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("jal PCE const", bus.PCE, 32'h100);
        checkOutput("jal PCPlus4E const", bus.PCPlus4E, 32'h104);
        checkOutput("jal ImmExtE const", bus.ImmExtE, 32'h8);
        checkOutput("jal ResultSrcE const", 32'(bus.ResultSrcE), 32'd2);

        // Flush of a valid R-type while write-back still lands in x9
        applyStimulus("flush", 32'h40B50533, 32'h120, 1'b1, 5'd9, 32'hCAFE0009, 1'b1);
        applyStimulus("after-flush", 32'h00048033, 32'h124, 1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("flush-wb RD1E const", bus.RD1E, 32'hCAFE0009);

        // Random instruction stream against the model
        for (int n = 0; n < 400; n++) begin
            rnd = $urandom();
            ins = {rnd[31:7], opTable[$urandom_range(0, 6)]};
            if ($urandom_range(0, 9) == 0) ins = {rnd[31:7], 7'(rnd[6:0])};
            applyStimulus("rand", ins, $urandom() & 32'hFFFF_FFFC,
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                          $urandom(), ($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset between edges clears everything immediately
        applyStimulus("pre-rst", 32'h00C58633, 32'h300, 1'b1, 5'd11, 32'h0BADF00D, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        checkAll("async-rst", '0);
        clearModel();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus("post-rst-rd", 32'h0095_8633, 32'h304, 1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("post-rst x11 const", bus.RD1E, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
